// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits). It reports each received word with a
// one-cycle dout_vld pulse together with framing and parity error flags.
//
// Optional build macro UART_RX_MAJORITY_EN: each bit value is the 2-of-3
// majority of three consecutive samples around mid-bit. Every mid-bit decision
// then moves one cycle later. When the macro is undefined, each bit is taken
// from a single sample at mid-bit.
module uart_rx_cfg #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_vld,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLK_DIV / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic                 s3;
  logic [1:0]           settle;
  logic                 armed;
  logic                 fall;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_l;
  logic                 perr_l;
  logic                 cnt_wrap;
  logic                 at_dec;
  logic                 samp_bit;
  logic                 par_bad;
  logic                 stop_last;

  // Two-flop synchroniser plus an edge-detect flop. The synchroniser resets
  // high, so a line that is held low across reset release would look like a
  // falling edge. 'armed' blocks edge detection until the synchronised line
  // has really been seen high after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      s1     <= din;
      s2     <= s1;
      s3     <= s2;
      settle <= {settle[0], 1'b1};
      if (settle[1] && s2) begin
        armed <= 1'b1;
      end
    end
  end

  assign fall     = armed & ~s2 & s3;
  assign cnt_wrap = (cnt == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(CLK_DIV / 2 + 1);

  logic maj_a;
  logic maj_b;

  // Hold the two earlier samples so that the majority vote can be taken
  // together with the live sample at CLK_DIV/2+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else begin
      if (cnt == CNT_PRE) begin
        maj_a <= s2;
      end
      if (cnt == CNT_MID) begin
        maj_b <= s2;
      end
    end
  end

  assign samp_bit = (maj_a & maj_b) | (maj_a & s2) | (maj_b & s2);
  assign at_dec   = (cnt == CNT_POST);
`else
  assign samp_bit = s2;
  assign at_dec   = (cnt == CNT_MID);
`endif

  // Odd mode wants an odd number of ones over data+parity, even mode an even one.
  assign par_bad   = (PARITY == 1) ? ~(^{shreg, samp_bit}) : (^{shreg, samp_bit});
  assign stop_last = (STOP_BITS == 1) || stop_idx;

  // Frame FSM. The bit timer free-runs while a frame is in progress. Results
  // are published one cycle after the final stop-bit decision, and the FSM
  // is already back in IDLE by then so that it catches a back-to-back start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      ferr_l     <= 1'b0;
      perr_l     <= 1'b0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (state != IDLE) begin
        cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (fall) begin
            state  <= START;
            cnt    <= '0;
            busy   <= 1'b1;
            ferr_l <= 1'b0;
            perr_l <= 1'b0;
          end
        end
        START: begin
          if (at_dec && samp_bit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (at_dec) begin
            shreg   <= {samp_bit, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          if (cnt_wrap && (bit_idx == IDX_LAST)) begin
            state    <= (PARITY != 0) ? PAR : STOP;
            stop_idx <= 1'b0;
          end
        end
        PAR: begin
          if (at_dec && par_bad) begin
            perr_l <= 1'b1;
          end
          if (cnt_wrap) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (at_dec) begin
            if (stop_last) begin
              state      <= IDLE;
              busy       <= 1'b0;
              dout_vld   <= 1'b1;
              dout       <= shreg;
              frame_err  <= ferr_l | ~samp_bit;
              parity_err <= perr_l;
            end else begin
              stop_idx <= 1'b1;
              if (!samp_bit) begin
                ferr_l <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg. It instantiates four
// receivers: a default 8N1 at 434 clk/bit, even and odd parity at 16 clk/bit,
// and a 7-bit two-stop-bit variant. Each serial line is driven with directed
// and random frames. Received words are compared with a frame-level
// reference model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int DIV0 = 434;
  localparam int DIVS = 16;

  typedef struct {
    int         ln;
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    int         cyc;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din_v;

  logic [7:0] d0_dout, d1_dout, d2_dout;
  logic [6:0] d3_dout;
  logic       d0_vld, d1_vld, d2_vld, d3_vld;
  logic       d0_ferr, d1_ferr, d2_ferr, d3_ferr;
  logic       d0_perr, d1_perr, d2_perr, d3_perr;
  logic       d0_busy, d1_busy, d2_busy, d3_busy;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  last_start = 0;
  rx_t got_q[$];
  rx_t exp_q[$];

  always #5 clk = ~clk;

  // Free-running cycle count used to timestamp start edges and pulses
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg u_def (
    .clk(clk), .rst_n(rst_n), .din(din_v[0]), .dout(d0_dout), .dout_vld(d0_vld),
    .frame_err(d0_ferr), .parity_err(d0_perr), .busy(d0_busy)
  );

  uart_rx_cfg #(.CLK_DIV(DIVS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .din(din_v[1]), .dout(d1_dout), .dout_vld(d1_vld),
    .frame_err(d1_ferr), .parity_err(d1_perr), .busy(d1_busy)
  );

  uart_rx_cfg #(.CLK_DIV(DIVS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din_v[2]), .dout(d2_dout), .dout_vld(d2_vld),
    .frame_err(d2_ferr), .parity_err(d2_perr), .busy(d2_busy)
  );

  uart_rx_cfg #(.CLK_DIV(DIVS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_d7 (
    .clk(clk), .rst_n(rst_n), .din(din_v[3]), .dout(d3_dout), .dout_vld(d3_vld),
    .frame_err(d3_ferr), .parity_err(d3_perr), .busy(d3_busy)
  );

  // Capture every valid pulse of every receiver, away from the active edge
  always @(negedge clk) begin
    if (d0_vld === 1'b1) got_q.push_back('{0, {1'b0, d0_dout}, d0_ferr, d0_perr, cyc});
    if (d1_vld === 1'b1) got_q.push_back('{1, {1'b0, d1_dout}, d1_ferr, d1_perr, cyc});
    if (d2_vld === 1'b1) got_q.push_back('{2, {1'b0, d2_dout}, d2_ferr, d2_perr, cyc});
    if (d3_vld === 1'b1) got_q.push_back('{3, {2'b00, d3_dout}, d3_ferr, d3_perr, cyc});
  end

  // Reference model: what a correct receiver reports for one frame on the wire
  function automatic rx_t model_frame(input int ln, input int nbits, input int pmode,
                                      input logic [8:0] data, input logic par_bit,
                                      input logic [1:0] stops, input int nstop);
    rx_t        r;
    int         ones;
    logic [8:0] mask;
    mask   = 9'((1 << nbits) - 1);
    r.ln   = ln;
    r.data = data & mask;
    ones   = 0;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    ones  += int'(par_bit);
    if (pmode == 1)      r.perr = ((ones % 2) == 0);
    else if (pmode == 2) r.perr = ((ones % 2) == 1);
    else                 r.perr = 1'b0;
    r.ferr = (stops[0] == 1'b0) || ((nstop == 2) && (stops[1] == 1'b0));
    r.cyc  = 0;
    return r;
  endfunction

  task automatic drive_bit(input int ln, input logic val, input int ncyc);
    din_v[ln] = val;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic send_frame(input int ln, input int div, input int nbits, input int pmode,
                            input int nstop, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stops);
    last_start = cyc;
    drive_bit(ln, 1'b0, div);
    for (int i = 0; i < nbits; i++) drive_bit(ln, data[i], div);
    if (pmode != 0) drive_bit(ln, par_bit, div);
    for (int i = 0; i < nstop; i++) drive_bit(ln, stops[i], div);
    exp_q.push_back(model_frame(ln, nbits, pmode, data, par_bit, stops, nstop));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    din_v = 4'hF;
    repeat (5) @(negedge clk);
    checks++;
    if ({d0_dout, d0_vld, d0_ferr, d0_perr, d0_busy} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_def: got %h expected 000",
               {d0_dout, d0_vld, d0_ferr, d0_perr, d0_busy});
    end
    checks++;
    if ({d3_dout, d3_vld, d3_ferr, d3_perr, d3_busy} !== 11'h000) begin
      failures++;
      $display("[TB] FAIL reset_d7: got %h expected 000",
               {d3_dout, d3_vld, d3_ferr, d3_perr, d3_busy});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || d0_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got pulses=%0d busy=%b expected 0 0", got_q.size(), d0_busy);
    end
  endtask

  task automatic test_basic;
    int lat;
    int exp_lat;
    got_q.delete();
    exp_q.delete();
    send_frame(0, DIV0, 8, 0, 1, 9'h0A5, 1'b0, 2'b11);
    drive_bit(0, 1'b1, DIV0);
    exp_lat = 3 + 9 * DIV0 + DIV0 / 2 + 1;
`ifdef UART_RX_MAJORITY_EN
    exp_lat = exp_lat + 1;
`endif
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL basic_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].ln, got_q[i].data, got_q[i].ferr, got_q[i].perr} !==
          {exp_q[i].ln, exp_q[i].data, exp_q[i].ferr, exp_q[i].perr}) begin
        failures++;
        $display("[TB] FAIL basic_frame[%0d]: got data=%h ferr=%b perr=%b expected data=%h ferr=%b perr=%b",
                 i, got_q[i].data, got_q[i].ferr, got_q[i].perr, exp_q[i].data, exp_q[i].ferr, exp_q[i].perr);
      end
    end
    if (got_q.size() > 0) begin
      lat = got_q[0].cyc - last_start;
      checks++;
      if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
        failures++;
        $display("[TB] FAIL basic_latency: got %0d expected %0d +/-1", lat, exp_lat);
      end
    end
    checks++;
    if (d0_busy !== 1'b0 || d0_dout !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL basic_hold: got busy=%b dout=%h expected 0 a5", d0_busy, d0_dout);
    end
  endtask

  task automatic test_glitch;
    got_q.delete();
    exp_q.delete();
    drive_bit(0, 1'b0, 100);
    checks++;
    if (d0_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL glitch_busy: got %b expected 1", d0_busy);
    end
    drive_bit(0, 1'b1, 200);
    checks++;
    if (d0_busy !== 1'b0 || got_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL glitch_abort: got busy=%b pulses=%0d expected 0 0", d0_busy, got_q.size());
    end
    send_frame(0, DIV0, 8, 0, 1, 9'h03C, 1'b0, 2'b11);
    drive_bit(0, 1'b1, DIV0);
    checks++;
    if (got_q.size() != 1 || got_q[0].data !== 9'h03C || got_q[0].ferr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL glitch_next: got pulses=%0d data=%h expected 1 03c", got_q.size(),
               (got_q.size() > 0) ? got_q[0].data : 9'h1FF);
    end
  endtask

  task automatic test_frame_err;
    got_q.delete();
    exp_q.delete();
    send_frame(0, DIV0, 8, 0, 1, 9'h05A, 1'b0, 2'b10);
    drive_bit(0, 1'b1, DIV0);
    send_frame(0, DIV0, 8, 0, 1, 9'h012, 1'b0, 2'b11);
    drive_bit(0, 1'b1, DIV0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL ferr_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].data, got_q[i].ferr, got_q[i].perr} !==
          {exp_q[i].data, exp_q[i].ferr, exp_q[i].perr}) begin
        failures++;
        $display("[TB] FAIL ferr_frame[%0d]: got data=%h ferr=%b perr=%b expected data=%h ferr=%b perr=%b",
                 i, got_q[i].data, got_q[i].ferr, got_q[i].perr, exp_q[i].data, exp_q[i].ferr, exp_q[i].perr);
      end
    end
  endtask

  task automatic test_parity;
    logic [8:0] data;
    logic       pb;
    logic [1:0] st;
    got_q.delete();
    exp_q.delete();
    send_frame(1, DIVS, 8, 2, 1, 9'h03C, 1'b1, 2'b11);
    drive_bit(1, 1'b1, DIVS);
    send_frame(1, DIVS, 8, 2, 1, 9'h03C, 1'b0, 2'b11);
    drive_bit(1, 1'b1, DIVS);
    send_frame(2, DIVS, 8, 1, 1, 9'h001, 1'b0, 2'b11);
    drive_bit(2, 1'b1, DIVS);
    for (int n = 0; n < 32; n++) begin
      data = 9'($urandom_range(0, 255));
      pb   = 1'($urandom_range(0, 1));
      st   = {1'b1, ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1};
      send_frame(1 + (n % 2), DIVS, 8, 1 + (n % 2) == 1 ? 2 : 1, 1, data, pb, st);
      drive_bit(1 + (n % 2), 1'b1, DIVS);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL parity_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].ln, got_q[i].data, got_q[i].ferr, got_q[i].perr} !==
          {exp_q[i].ln, exp_q[i].data, exp_q[i].ferr, exp_q[i].perr}) begin
        failures++;
        $display("[TB] FAIL parity_frame[%0d]: got ln=%0d data=%h ferr=%b perr=%b expected ln=%0d data=%h ferr=%b perr=%b",
                 i, got_q[i].ln, got_q[i].data, got_q[i].ferr, got_q[i].perr,
                 exp_q[i].ln, exp_q[i].data, exp_q[i].ferr, exp_q[i].perr);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] st;
    got_q.delete();
    exp_q.delete();
    send_frame(0, DIV0, 8, 0, 1, 9'h000, 1'b0, 2'b11);
    send_frame(0, DIV0, 8, 0, 1, 9'h0FF, 1'b0, 2'b11);
    send_frame(0, DIV0, 8, 0, 1, 9'h081, 1'b0, 2'b11);
    drive_bit(0, 1'b1, DIV0);
    send_frame(3, DIVS, 7, 0, 2, 9'h07F, 1'b0, 2'b11);
    for (int n = 0; n < 10; n++) begin
      st = {1'b1, ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1};
      send_frame(3, DIVS, 7, 0, 2, 9'($urandom_range(0, 127)), 1'b0, st);
    end
    drive_bit(3, 1'b1, DIVS);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].ln, got_q[i].data, got_q[i].ferr, got_q[i].perr} !==
          {exp_q[i].ln, exp_q[i].data, exp_q[i].ferr, exp_q[i].perr}) begin
        failures++;
        $display("[TB] FAIL b2b_frame[%0d]: got ln=%0d data=%h ferr=%b expected ln=%0d data=%h ferr=%b",
                 i, got_q[i].ln, got_q[i].data, got_q[i].ferr, exp_q[i].ln, exp_q[i].data, exp_q[i].ferr);
      end
    end
    for (int i = 1; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].cyc - got_q[i-1].cyc != 10 * DIV0) begin
        failures++;
        $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected %0d", i,
                 got_q[i].cyc - got_q[i-1].cyc, 10 * DIV0);
      end
    end
  endtask

  task automatic test_reset_midframe;
    got_q.delete();
    exp_q.delete();
    drive_bit(0, 1'b0, DIV0);
    drive_bit(0, 1'b1, DIV0);
    drive_bit(0, 1'b1, DIV0);
    drive_bit(0, 1'b0, DIV0 / 2);
    checks++;
    if (d0_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_busy: got %b expected 1", d0_busy);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({d0_dout, d0_vld, d0_ferr, d0_perr, d0_busy} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL midrst_outputs: got %h expected 000",
               {d0_dout, d0_vld, d0_ferr, d0_perr, d0_busy});
    end
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(0, 1'b0, 3 * DIV0);
    checks++;
    if (d0_busy !== 1'b0 || got_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL midrst_low_line: got busy=%b pulses=%0d expected 0 0", d0_busy, got_q.size());
    end
    drive_bit(0, 1'b1, DIV0);
    send_frame(0, DIV0, 8, 0, 1, 9'h099, 1'b0, 2'b11);
    drive_bit(0, 1'b1, DIV0);
    checks++;
    if (got_q.size() != 1 || got_q[0].data !== 9'h099 || got_q[0].ferr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_next: got pulses=%0d data=%h expected 1 099", got_q.size(),
               (got_q.size() > 0) ? got_q[0].data : 9'h1FF);
    end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority;
    logic [7:0] data;
    data = 8'h66;
    got_q.delete();
    exp_q.delete();
    drive_bit(1, 1'b0, DIVS);
    for (int i = 0; i < 8; i++) begin
      drive_bit(1, data[i], DIVS / 2);
      drive_bit(1, ~data[i], 1);
      drive_bit(1, data[i], DIVS / 2 - 1);
    end
    drive_bit(1, 1'b0, DIVS);
    drive_bit(1, 1'b1, DIVS);
    drive_bit(1, 1'b1, DIVS);
    exp_q.push_back(model_frame(1, 8, 2, 9'h066, 1'b0, 2'b11, 1));
    checks++;
    if (got_q.size() != 1 || got_q[0].data !== exp_q[0].data || got_q[0].perr !== exp_q[0].perr) begin
      failures++;
      $display("[TB] FAIL majority_spike: got pulses=%0d data=%h expected 1 %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0].data : 9'h1FF, exp_q[0].data);
    end
  endtask
`endif

  // Safety net so that a stuck run still ends with a report
  initial begin
    #1_200_000;
    $display("[TB] FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  // Test sequence
  initial begin
    rst_n = 1'b0;
    din_v = 4'hF;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver in the serial loopback path.
- Configurable baud divisor, data width, parity mode and stop-bit count.
- Start-bit glitch rejection and per-frame framing/parity error flags.
- Feeds received words to the TX/loopback or command logic via a single-cycle valid pulse.

Parameters:
CLK_DIV, 434, clk cycles per bit (50 MHz / 115200); legal range >= 8.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked: 1 or 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
din  input  1  serial line from PC, idle high, asynchronous to clk
dout  output  DATA_BITS  received word, LSB = first bit on line
dout_vld  output  1  one-cycle pulse; dout/frame_err/parity_err valid in that cycle
frame_err  output  1  a stop-bit sample was 0 (qualified by dout_vld)
parity_err  output  1  parity mismatch; always 0 when PARITY=0 (qualified by dout_vld)
busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Outputs reset to: dout=0, dout_vld=0, frame_err=0, parity_err=0, busy=0.
- Synchroniser flops reset to 1.
- din passes through 2 synchroniser flops (s1, s2); all decisions use s2.
- Falling edge = s2 low while a third flop s3 (s2 delayed) is high.
- Bit counter cnt: width $clog2(CLK_DIV); counts 0..CLK_DIV-1, wraps to 0.
- Mid-bit sample point: cnt == CLK_DIV/2 (integer divide).
- Bit index counter: width $clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: on falling edge -> START with cnt=0. Edges during non-IDLE states are ignored.
- START: at mid-bit, if sample = 1 -> IDLE (false start; no dout_vld, no error). Else continue; at cnt wrap -> DATA.
- DATA: sample at mid-bit into shift register, LSB first. After DATA_BITS bits, at cnt wrap -> PAR if PARITY != 0, else STOP.
- PAR: sample at mid-bit. Odd mode expects an odd count of ones over data+parity; even mode expects an even count. Mismatch latches the internal parity error. At cnt wrap -> STOP.
- STOP: sample each stop bit at mid-bit; any 0 latches the internal framing error. At the mid-bit sample of the LAST stop bit, FSM returns to IDLE immediately, without waiting for the bit end. This allows back-to-back frames with the next start edge arriving half a bit later.
- Output update, registered: in the cycle after the last stop-bit sample, dout <= shift register, frame_err/parity_err <= latched flags, dout_vld=1 for exactly one cycle.
- dout and error flags hold their values until the next frame's dout_vld. Internal error latches clear on entry to START.
- A frame with errors still produces dout_vld, carrying the data as received.
- Latency: dout_vld rises 3 + (1 + DATA_BITS + (PARITY!=0) + STOP_BITS - 1)*CLK_DIV + CLK_DIV/2 + 1 cycles after din falls (±1 for synchroniser phase).
- Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded. If din is low when reset is released, no frame is detected until a fresh high-to-low edge.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value is the 2-of-3 majority of s2 at cnt = CLK_DIV/2-1, CLK_DIV/2 and CLK_DIV/2+1. Applies to start, data, parity and stop bits. Decisions that happen at mid-bit (false-start abort, returning to IDLE in STOP) are made at CLK_DIV/2+1. Output latency grows by 1 cycle.
- Undefined: single sample of s2 at cnt = CLK_DIV/2; no extra registers.

Test Plan:
- Default 8N1, din carries 0xA5 at 434 clk/bit -> exactly one dout_vld pulse, dout=0xA5, frame_err=0, parity_err=0, busy low after the pulse.
- din low for 100 cycles, then high (glitch) -> FSM returns to IDLE at the mid-bit point, no dout_vld; a following 0x3C frame is received correctly.
- 8N1, 0x5A sent with stop bit driven 0 -> dout_vld=1, dout=0x5A, frame_err=1; next frame 0x12 with a good stop bit -> frame_err=0.
- PARITY=2, 0x3C sent with parity bit 1 (wrong) -> parity_err=1. Same frame with parity bit 0 -> parity_err=0. PARITY=1 with 0x01 and parity bit 0 -> parity_err=0.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three dout_vld pulses spaced 10*434 cycles apart, values in order. DATA_BITS=7, STOP_BITS=2 variant, 0x7F -> dout=7'h7F.
- rst_n asserted in the middle of the data bits of 0xC3 -> all outputs 0 within the reset; after release, frame 0x99 -> dout=0x99, no spurious pulse.
- With UART_RX_MAJORITY_EN defined, a 1-cycle inverted spike at cnt=CLK_DIV/2 on each data bit of 0x66 -> dout=0x66.
